// File: rtl/fdc_pkg.sv
// Shared constants and helpers for the fdownconvert_mc multi-channel downconverter.
// Optional round-half-up in the lanes is enabled by defining FDC_ROUND_EN.
package fdc_pkg;

    localparam int FDC_LAT  = 6;
    localparam int SAT_MAXW = 64;

    function automatic int fdc_pw(input int dw, input int lw);
        return dw + lw;
    endfunction

    // Clamp a wide signed value into the range of an ow-bit signed number.
    function automatic logic signed [SAT_MAXW-1:0] fdc_sat(
        input logic signed [SAT_MAXW-1:0] x,
        input int                         ow
    );
        logic signed [SAT_MAXW-1:0] hi;
        logic signed [SAT_MAXW-1:0] lo;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (ow - 1));
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end else begin
            return x;
        end
    endfunction

endpackage

// File: rtl/fdc_lane.sv
// One downconverter channel: LO mixing, I/Q differencing, gain shift, saturation and sticky flag.
// Defining FDC_ROUND_EN adds round-half-up ahead of saturation; otherwise the shift floors.
module fdc_lane
    import fdc_pkg::*;
#(
    parameter int DW = 16,
    parameter int LW = 18,
    parameter int OW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mod2_i,
    input  logic signed [DW-1:0] a_i,
    input  logic signed [LW-1:0] cos_i,
    input  logic signed [LW-1:0] sin_i,
    input  logic [1:0]           shift_i,
    input  logic                 err_clr_i,
    output logic signed [OW-1:0] data_o,
    output logic                 sat_flag_o
);

    localparam int         PW  = fdc_pw(DW, LW);
    localparam logic [5:0] SHB = 6'(PW - OW);

    logic signed [PW-1:0]       a_ext_s, cos_ext_s, sin_ext_s;
    logic signed [PW-1:0]       p0i_q, p0q_q, p1i_q, p1q_q, p2i_q, p2q_q;
    logic signed [PW:0]         di_q, dq_q, dq_d_q;
    logic signed [PW:0]         mux_s;
    logic [5:0]                 shamt_s;
    logic signed [SAT_MAXW-1:0] wide_s, shr_s, sat_s;
    logic                       clamp_s;
    logic signed [OW-1:0]       data_d;
    logic                       sat_d;

    assign a_ext_s   = {{LW{a_i[DW-1]}}, a_i};
    assign cos_ext_s = {{DW{cos_i[LW-1]}}, cos_i};
    assign sin_ext_s = {{DW{sin_i[LW-1]}}, sin_i};

    // Output select, gain shift (optionally rounded), clamp and flag next-state.
    always_comb begin
        mux_s   = mod2_i ? dq_d_q : di_q;
        shamt_s = SHB - {4'd0, shift_i};
        wide_s  = {{(SAT_MAXW-PW-1){mux_s[PW]}}, mux_s};
`ifdef FDC_ROUND_EN
        wide_s  = wide_s + (64'sd1 <<< (shamt_s - 6'd1));
`endif
        shr_s   = wide_s >>> shamt_s;
        sat_s   = fdc_sat(shr_s, OW);
        clamp_s = (sat_s != shr_s);
        data_d  = sat_s[OW-1:0];
        if (clamp_s) begin
            sat_d = 1'b1;
        end else if (err_clr_i) begin
            sat_d = 1'b0;
        end else begin
            sat_d = sat_flag_o;
        end
    end

    // Product, delay and difference pipeline plus output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            p0i_q      <= '0;
            p0q_q      <= '0;
            p1i_q      <= '0;
            p1q_q      <= '0;
            p2i_q      <= '0;
            p2q_q      <= '0;
            di_q       <= '0;
            dq_q       <= '0;
            dq_d_q     <= '0;
            data_o     <= '0;
            sat_flag_o <= 1'b0;
        end else begin
            p0i_q      <= a_ext_s * cos_ext_s;
            p0q_q      <= a_ext_s * sin_ext_s;
            p1i_q      <= p0i_q;
            p1q_q      <= p0q_q;
            p2i_q      <= p1i_q;
            p2q_q      <= p1q_q;
            di_q       <= {p1i_q[PW-1], p1i_q} - {p2i_q[PW-1], p2i_q};
            dq_q       <= {p2q_q[PW-1], p2q_q} - {p1q_q[PW-1], p1q_q};
            dq_d_q     <= dq_q;
            data_o     <= data_d;
            sat_flag_o <= sat_d;
        end
    end

endmodule

// File: rtl/fdownconvert_mc.sv
// Multi-channel near-IQ downconverter top: shared LO reorder, fill gating, timing error tracking.
// Build option FDC_ROUND_EN selects rounded instead of floored lane outputs.
module fdownconvert_mc
    import fdc_pkg::*;
#(
    parameter int DW  = 16,
    parameter int LW  = 18,
    parameter int OW  = 16,
    parameter int NCH = 2,
    parameter int ECW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mod2,
    input  logic [LW-1:0]     cosd,
    input  logic [LW-1:0]     sind,
    input  logic [NCH*DW-1:0] a_data,
    input  logic              a_gate,
    input  logic [1:0]        shift,
    input  logic              err_clr,
    output logic [NCH*OW-1:0] o_data,
    output logic              o_gate,
    output logic              o_trig,
    output logic [NCH-1:0]    sat_flag,
    output logic              time_err,
    output logic [ECW-1:0]    err_count
);

    localparam int FW = $clog2(FDC_LAT + 1);

    logic [LW-1:0]  cos_d1_q, sin_d1_q, cos_d2_q, sin_d2_q, cos_r_q, sin_r_q;
    logic [FW-1:0]  fill_q, fill_d;
    logic           fill_done_s;
    logic           last_mod2_q;
    logic           time_err_q, time_err_d;
    logic [ECW-1:0] err_count_q, err_count_d;
    logic           o_gate_q, o_trig_q;

    // Next-state for fill counter, timing error and saturating error count.
    always_comb begin
        fill_done_s = (fill_q == FW'(FDC_LAT));
        if (fill_done_s) begin
            fill_d = fill_q;
        end else begin
            fill_d = fill_q + FW'(1);
        end
        time_err_d = (mod2 == last_mod2_q) | ~a_gate;
        if (err_clr) begin
            err_count_d = {ECW{1'b0}};
        end else if (time_err_q && (err_count_q != {ECW{1'b1}})) begin
            err_count_d = err_count_q + ECW'(1);
        end else begin
            err_count_d = err_count_q;
        end
    end

    // The LO pair presented to the lanes alternates between current and two-cycle-old samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            cos_d1_q    <= '0;
            sin_d1_q    <= '0;
            cos_d2_q    <= '0;
            sin_d2_q    <= '0;
            cos_r_q     <= '0;
            sin_r_q     <= '0;
            fill_q      <= '0;
            last_mod2_q <= 1'b0;
            time_err_q  <= 1'b0;
            err_count_q <= '0;
            o_gate_q    <= 1'b0;
            o_trig_q    <= 1'b0;
        end else begin
            cos_d1_q    <= cosd;
            sin_d1_q    <= sind;
            cos_d2_q    <= cos_d1_q;
            sin_d2_q    <= sin_d1_q;
            cos_r_q     <= mod2 ? cosd : cos_d2_q;
            sin_r_q     <= mod2 ? sind : sin_d2_q;
            fill_q      <= fill_d;
            last_mod2_q <= mod2;
            time_err_q  <= time_err_d;
            err_count_q <= err_count_d;
            o_gate_q    <= fill_done_s & a_gate;
            o_trig_q    <= mod2;
        end
    end

    assign o_gate    = o_gate_q;
    assign o_trig    = o_trig_q;
    assign time_err  = time_err_q;
    assign err_count = err_count_q;

    for (genvar c = 0; c < NCH; c++) begin : g_lane
        fdc_lane #(
            .DW (DW),
            .LW (LW),
            .OW (OW)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .mod2_i     (mod2),
            .a_i        (a_data[c*DW +: DW]),
            .cos_i      (cos_r_q),
            .sin_i      (sin_r_q),
            .shift_i    (shift),
            .err_clr_i  (err_clr),
            .data_o     (o_data[c*OW +: OW]),
            .sat_flag_o (sat_flag[c])
        );
    end

endmodule

// File: tb/tb_fdownconvert_mc.sv
// Self-checking bench for fdownconvert_mc: directed scenarios plus randomized stimulus
// compared every cycle against a sample-history reference model.
module tb_fdownconvert_mc;

    localparam int DW = 16, LW = 18, OW = 16, NCH = 2, ECW = 16;
    localparam int SHB = DW + LW - OW;
    localparam longint OMAX = (64'sd1 <<< (OW - 1)) - 64'sd1;
    localparam longint OMIN = -(64'sd1 <<< (OW - 1));
    localparam longint EMAX = (64'sd1 <<< ECW) - 64'sd1;
`ifdef FDC_ROUND_EN
    localparam longint EXP_POS = 64'sd8192;
`else
    localparam longint EXP_POS = 64'sd8191;
`endif
    localparam longint EXP_NEG = -64'sd8192;

    logic              clk = 1'b0;
    logic              rst, mod2, a_gate, err_clr;
    logic [LW-1:0]     cosd, sind;
    logic [NCH*DW-1:0] a_data;
    logic [1:0]        shift;
    logic [NCH*OW-1:0] o_data;
    logic              o_gate, o_trig, time_err;
    logic [NCH-1:0]    sat_flag;
    logic [ECW-1:0]    err_count;

    always #5 clk = ~clk;

    fdownconvert_mc #(.DW(DW), .LW(LW), .OW(OW), .NCH(NCH), .ECW(ECW)) dut (
        .clk(clk), .rst(rst), .mod2(mod2), .cosd(cosd), .sind(sind),
        .a_data(a_data), .a_gate(a_gate), .shift(shift), .err_clr(err_clr),
        .o_data(o_data), .o_gate(o_gate), .o_trig(o_trig), .sat_flag(sat_flag),
        .time_err(time_err), .err_count(err_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: sample histories (index k = k edges ago) and expected outputs.
    longint   lo_c [3];
    longint   lo_s [3];
    longint   lor_c_prev, lor_s_prev;
    longint   p_i [NCH][6];
    longint   p_q [NCH][6];
    longint   exp_o [NCH];
    int       fill;
    bit       last_m, terr, exp_gate, exp_trig;
    longint   ecnt;
    logic [NCH-1:0] sflag;
    bit       m_nxt;

    task automatic check_val(input string tag, input logic signed [63:0] obs,
                             input logic signed [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic signed [63:0] och(input int c);
        return 64'($signed(o_data[c*OW +: OW]));
    endfunction

    task automatic model_edge();
        longint a, v, q, lrc, lrs;
        int sh;
        bit sat_ev;
        if (rst) begin
            for (int k = 0; k < 3; k++) begin lo_c[k] = 0; lo_s[k] = 0; end
            for (int c = 0; c < NCH; c++) begin
                for (int k = 0; k < 6; k++) begin p_i[c][k] = 0; p_q[c][k] = 0; end
                exp_o[c] = 0;
            end
            lor_c_prev = 0; lor_s_prev = 0;
            fill = 0; last_m = 0; terr = 0; ecnt = 0; sflag = '0;
            exp_gate = 0; exp_trig = 0;
        end else begin
            lo_c[2] = lo_c[1]; lo_c[1] = lo_c[0]; lo_c[0] = longint'($signed(cosd));
            lo_s[2] = lo_s[1]; lo_s[1] = lo_s[0]; lo_s[0] = longint'($signed(sind));
            lrc = mod2 ? lo_c[0] : lo_c[2];
            lrs = mod2 ? lo_s[0] : lo_s[2];
            for (int c = 0; c < NCH; c++) begin
                for (int k = 5; k > 0; k--) begin
                    p_i[c][k] = p_i[c][k-1];
                    p_q[c][k] = p_q[c][k-1];
                end
                a = longint'($signed(a_data[c*DW +: DW]));
                p_i[c][0] = a * lor_c_prev;
                p_q[c][0] = a * lor_s_prev;
                v  = mod2 ? (p_q[c][5] - p_q[c][4]) : (p_i[c][3] - p_i[c][4]);
                sh = SHB - int'(shift);
`ifdef FDC_ROUND_EN
                v  = v + (64'sd1 <<< (sh - 1));
`endif
                q  = v >>> sh;
                sat_ev = (q > OMAX) || (q < OMIN);
                exp_o[c] = (q > OMAX) ? OMAX : ((q < OMIN) ? OMIN : q);
                if (sat_ev) sflag[c] = 1'b1;
                else if (err_clr) sflag[c] = 1'b0;
            end
            lor_c_prev = lrc;
            lor_s_prev = lrs;
            if (err_clr) ecnt = 0;
            else if (terr && ecnt < EMAX) ecnt++;
            terr     = (mod2 == last_m) || !a_gate;
            last_m   = mod2;
            exp_gate = (fill >= 6) && a_gate;
            if (fill < 6) fill++;
            exp_trig = mod2;
        end
    endtask

    task automatic check_all();
        for (int c = 0; c < NCH; c++) check_val($sformatf("o_data%0d", c), och(c), exp_o[c]);
        check_val("o_gate", 64'(o_gate), 64'(exp_gate));
        check_val("o_trig", 64'(o_trig), 64'(exp_trig));
        check_val("sat_flag", 64'(sat_flag), 64'(sflag));
        check_val("time_err", 64'(time_err), 64'(terr));
        check_val("err_count", 64'(err_count), ecnt);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic drive_mod2(input bit glitch);
        if (glitch) begin
            mod2 = ~m_nxt;
        end else begin
            mod2  = m_nxt;
            m_nxt = ~m_nxt;
        end
    endtask

    task automatic rand_lo();
        int v;
        v = int'($urandom_range(0, 262142)) - 131071;
        cosd = v[LW-1:0];
        v = int'($urandom_range(0, 262142)) - 131071;
        sind = v[LW-1:0];
    endtask

    task automatic rand_inputs();
        for (int c = 0; c < NCH; c++) a_data[c*DW +: DW] = DW'($urandom);
        rand_lo();
        shift   = 2'($urandom_range(0, 3));
        a_gate  = ($urandom_range(0, 9) != 0);
        err_clr = ($urandom_range(0, 19) == 0);
        drive_mod2($urandom_range(0, 19) == 0);
    endtask

    initial begin
        int te_sum;
        rst = 1'b1; mod2 = 1'b0; m_nxt = 1'b1; a_gate = 1'b0; err_clr = 1'b0;
        cosd = '0; sind = '0; a_data = '0; shift = 2'd0;
        repeat (3) begin drive_mod2(1'b0); cycle(); end

        // Reset release: fill gating with zero data
        rst = 1'b0; m_nxt = 1'b1; a_gate = 1'b1;
        rand_lo();
        for (int k = 1; k <= 10; k++) begin
            drive_mod2(1'b0);
            cycle();
            check_val("fill_gate", 64'(o_gate), (k > 6) ? 64'sd1 : 64'sd0);
            if (k <= 6) check_val("fill_data", 64'(o_data), 64'sd0);
            check_val("fill_terr", 64'(time_err), 64'sd0);
        end

        // Full-scale cosine, data in phase then out of phase with mod2
        cosd = 18'd131071; sind = '0; shift = 2'd0;
        for (int k = 0; k < 16; k++) begin
            drive_mod2(1'b0);
            a_data[0 +: DW]  = mod2 ? 16'h2000 : 16'hE000;
            a_data[DW +: DW] = '0;
            cycle();
            if (k >= 8) begin
                if (o_trig) check_val("q_zero", och(0), 64'sd0);
                else        check_val("i_pos", och(0), EXP_POS);
            end
        end
        for (int k = 0; k < 12; k++) begin
            drive_mod2(1'b0);
            a_data[0 +: DW] = mod2 ? 16'hE000 : 16'h2000;
            cycle();
            if (k >= 6 && !o_trig) check_val("i_neg", och(0), EXP_NEG);
        end

        // Flush, then saturate channel 1 only with shift=3
        a_data = '0; err_clr = 1'b1;
        for (int k = 0; k < 8; k++) begin drive_mod2(1'b0); cycle(); err_clr = 1'b0; end
        shift = 2'd3;
        for (int k = 0; k < 12; k++) begin
            drive_mod2(1'b0);
            a_data[DW +: DW] = mod2 ? 16'h7FFF : 16'h8001;
            cycle();
            if (k >= 8 && !o_trig) check_val("ch1_clamp", och(1), OMAX);
        end
        check_val("sat_flags", 64'(sat_flag), 64'sd2);

        // Single mod2 glitch: one time_err pulse, count of one
        err_clr = 1'b1; drive_mod2(1'b0); cycle(); err_clr = 1'b0;
        te_sum = 0;
        drive_mod2(1'b1); cycle(); te_sum += int'(time_err);
        for (int k = 0; k < 4; k++) begin drive_mod2(1'b0); cycle(); te_sum += int'(time_err); end
        check_val("glitch_pulses", 64'(te_sum), 64'sd1);
        check_val("glitch_count", 64'(err_count), 64'sd1);

        // err_clr coincident with an increment
        drive_mod2(1'b1); cycle();
        err_clr = 1'b1; drive_mod2(1'b0); cycle();
        check_val("clr_wins", 64'(err_count), 64'sd0);
        err_clr = 1'b0; drive_mod2(1'b0); cycle();
        check_val("clr_hold", 64'(err_count), 64'sd0);

        // Randomized stream
        for (int k = 0; k < 400; k++) begin rand_inputs(); cycle(); end

        // One-cycle reset mid-stream
        rst = 1'b1; rand_inputs(); cycle();
        check_val("rst_data", 64'(o_data), 64'sd0);
        check_val("rst_gate", 64'(o_gate), 64'sd0);
        check_val("rst_trig", 64'(o_trig), 64'sd0);
        check_val("rst_sat", 64'(sat_flag), 64'sd0);
        check_val("rst_terr", 64'(time_err), 64'sd0);
        check_val("rst_ecnt", 64'(err_count), 64'sd0);
        rst = 1'b0; m_nxt = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            rand_inputs();
            a_gate = 1'b1;
            cycle();
            check_val("refill_gate", 64'(o_gate), (k > 6) ? 64'sd1 : 64'sd0);
        end
        for (int k = 0; k < 100; k++) begin rand_inputs(); cycle(); end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
